// File: rtl/rv_test_monitor_pkg.sv
// Shared types and defaults for the riscv-tests pass/fail monitor.
package rv_test_pkg;

   // Monitor FSM states; also exported on the debug port.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   // riscv-tests register conventions: gp holds the test number, x26/x27 done/result.
   localparam int unsigned DEF_TESTNUM_REG = 3;
   localparam int unsigned DEF_DONE_REG    = 26;
   localparam int unsigned DEF_RESULT_REG  = 27;
   localparam int unsigned DEF_PASS_VALUE  = 1;

   // 32-bit increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/rv_test_monitor_if.sv
// Snooped register-file write bus, ports flattened (port i at [i*W +: W]).
// Handshake: wr_en[i] is a pure valid strobe for port i; there is no ready,
// the monitor only observes and never back-pressures the register file.
interface rv_test_monitor_if #(
   parameter int unsigned WR_PORTS = 1,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 5
);
   logic [WR_PORTS-1:0]        wr_en;
   logic [WR_PORTS*REG_AW-1:0] wr_addr;
   logic [WR_PORTS*DATA_W-1:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/rv_wr_snoop.sv
// Matches all write ports against one target register; the highest
// port index wins when several ports hit in the same cycle.
module rv_wr_snoop #(
   parameter int unsigned WR_PORTS = 1,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned TARGET   = 0
) (
   input  logic [WR_PORTS-1:0]        wr_en,
   input  logic [WR_PORTS*REG_AW-1:0] wr_addr,
   input  logic [WR_PORTS*DATA_W-1:0] wr_data,
   output logic                       hit,
   output logic [DATA_W-1:0]          data
);

   // Ascending scan so later (higher) ports override earlier ones; x0 never matches.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < int'(WR_PORTS); i++) begin
         if (wr_en[i] && (TARGET != 0) &&
             (wr_addr[i*REG_AW +: REG_AW] == REG_AW'(TARGET))) begin
            hit  = 1'b1;
            data = wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/rv_test_monitor.sv
// Pass/fail monitor for riscv-tests programs: shadows test-number/done/result
// registers from register-file writes, waits a settle window after done,
// then latches a sticky verdict. A run-cycle watchdog flags hung programs.
module rv_test_monitor
   import rv_test_pkg::*;
#(
   parameter int unsigned WR_PORTS       = 1,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned REG_AW         = 5,
   parameter int unsigned TESTNUM_REG    = DEF_TESTNUM_REG,
   parameter int unsigned DONE_REG       = DEF_DONE_REG,
   parameter int unsigned RESULT_REG     = DEF_RESULT_REG,
   parameter int unsigned PASS_VALUE     = DEF_PASS_VALUE,
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   rv_test_monitor_if.slave    wr_bus,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic                timeout,
   output logic [DATA_W-1:0]   testnum,
   output logic [DATA_W-1:0]   result,
   output logic [31:0]         cycles,
   output state_t              dbg_state
);

   localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] testnum_q, testnum_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [31:0]       cycles_q, cycles_d;
   logic [SCW-1:0]    settle_q, settle_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              timeout_q, timeout_d;

   logic              tn_hit, dn_hit, rs_hit;
   logic [DATA_W-1:0] tn_data, dn_data, rs_data;
   logic              done_wr;

   rv_wr_snoop #(.WR_PORTS(WR_PORTS), .DATA_W(DATA_W), .REG_AW(REG_AW), .TARGET(TESTNUM_REG))
   u_snoop_testnum (
      .wr_en(wr_bus.wr_en), .wr_addr(wr_bus.wr_addr), .wr_data(wr_bus.wr_data),
      .hit(tn_hit), .data(tn_data)
   );

   rv_wr_snoop #(.WR_PORTS(WR_PORTS), .DATA_W(DATA_W), .REG_AW(REG_AW), .TARGET(DONE_REG))
   u_snoop_done (
      .wr_en(wr_bus.wr_en), .wr_addr(wr_bus.wr_addr), .wr_data(wr_bus.wr_data),
      .hit(dn_hit), .data(dn_data)
   );

   rv_wr_snoop #(.WR_PORTS(WR_PORTS), .DATA_W(DATA_W), .REG_AW(REG_AW), .TARGET(RESULT_REG))
   u_snoop_result (
      .wr_en(wr_bus.wr_en), .wr_addr(wr_bus.wr_addr), .wr_data(wr_bus.wr_data),
      .hit(rs_hit), .data(rs_data)
   );

   // The winning write to the done register ends the run only if it is non-zero.
   assign done_wr = dn_hit && (|dn_data);

   // Next-state, shadow, counter and registered-output logic.
   always_comb begin
      state_d   = state_q;
      testnum_d = testnum_q;
      result_d  = result_q;
      cycles_d  = cycles_q;
      settle_d  = settle_q;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d   = ST_RUN;
               testnum_d = '0;
               result_d  = '0;
               cycles_d  = '0;
               settle_d  = '0;
            end
            ST_RUN: begin
               cycles_d = sat_inc32(cycles_q);
               if (tn_hit) testnum_d = tn_data;
               if (rs_hit) result_d = rs_data;
               // Done has priority over a watchdog expiring on the same edge.
               if (done_wr) begin
                  if (SETTLE_CYCLES == 0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d  = ST_SETTLE;
                     settle_d = SCW'(SETTLE_CYCLES);
                  end
               end else if ((TIMEOUT_CYCLES != 0) && (cycles_d >= 32'(TIMEOUT_CYCLES))) begin
                  state_d = ST_TIMEOUT;
               end
            end
            ST_SETTLE: begin
               cycles_d = sat_inc32(cycles_q);
               if (tn_hit) testnum_d = tn_data;
               if (rs_hit) result_d = rs_data;
               if (settle_q <= SCW'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  settle_d = settle_q - SCW'(1);
               end
            end
            ST_DONE, ST_TIMEOUT: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Verdict follows the state being entered so the outputs are registered.
      done_d    = (state_d == ST_DONE) || (state_d == ST_TIMEOUT);
      pass_d    = (state_d == ST_DONE) && (result_d == DATA_W'(PASS_VALUE));
      fail_d    = ((state_d == ST_DONE) && (result_d != DATA_W'(PASS_VALUE))) ||
                  (state_d == ST_TIMEOUT);
      timeout_d = (state_d == ST_TIMEOUT);
   end

   // State and shadow registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         testnum_q <= '0;
         result_q  <= '0;
         cycles_q  <= '0;
         settle_q  <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         testnum_q <= testnum_d;
         result_q  <= result_d;
         cycles_q  <= cycles_d;
         settle_q  <= settle_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
      end
   end

   assign done      = done_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign timeout   = timeout_q;
   assign testnum   = testnum_q;
   assign result    = result_q;
   assign cycles    = cycles_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed bench for rv_test_monitor: dut_a settles for 2 cycles with a
// 50-cycle watchdog, dut_z has no settle window and no watchdog.
module tb_rv_test_monitor;
   import rv_test_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   logic en_a, en_z;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   rv_test_monitor_if #(.WR_PORTS(2), .DATA_W(32), .REG_AW(5)) bus_a ();
   rv_test_monitor_if #(.WR_PORTS(2), .DATA_W(32), .REG_AW(5)) bus_z ();

   logic        a_done, a_pass, a_fail, a_timeout;
   logic [31:0] a_testnum, a_result, a_cycles;
   state_t      a_state;
   logic        z_done, z_pass, z_fail, z_timeout;
   logic [31:0] z_testnum, z_result, z_cycles;
   state_t      z_state;

   rv_test_monitor #(.WR_PORTS(2), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(50)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .wr_bus(bus_a),
      .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
      .testnum(a_testnum), .result(a_result), .cycles(a_cycles), .dbg_state(a_state)
   );

   rv_test_monitor #(.WR_PORTS(2), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(0)) dut_z (
      .clk(clk), .rst(rst), .en(en_z), .wr_bus(bus_z),
      .done(z_done), .pass(z_pass), .fail(z_fail), .timeout(z_timeout),
      .testnum(z_testnum), .result(z_result), .cycles(z_cycles), .dbg_state(z_state)
   );

   wire [67:0] obs_a = {a_done, a_pass, a_fail, a_timeout, a_testnum, a_result};
   wire [67:0] obs_z = {z_done, z_pass, z_fail, z_timeout, z_testnum, z_result};

   // ---------------- scoreboard ----------------
   logic [67:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [67:0] pk(input bit dn, input bit ps, input bit fl, input bit to,
                                      input logic [31:0] tn, input logic [31:0] rs);
      return {dn, ps, fl, to, tn, rs};
   endfunction

   task automatic push(input logic [67:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check_vec(input string tag, input logic [67:0] obs);
      logic [67:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   task automatic check_u32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers (called at a negedge, return one negedge later) ----------------
   task automatic drive(input bit use_z, input logic [1:0] we,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
      if (use_z) begin
         bus_z.wr_en = we; bus_z.wr_addr = {a1, a0}; bus_z.wr_data = {d1, d0};
      end else begin
         bus_a.wr_en = we; bus_a.wr_addr = {a1, a0}; bus_a.wr_data = {d1, d0};
      end
      @(negedge clk);
      bus_a.wr_en = '0;
      bus_z.wr_en = '0;
   endtask

   task automatic wr1(input bit use_z, input logic [4:0] a, input logic [31:0] d);
      drive(use_z, 2'b01, a, 5'd0, d, 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      bit found;
      rst = 1'b0; en_a = 1'b0; en_z = 1'b0;
      bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
      bus_z.wr_en = '0; bus_z.wr_addr = '0; bus_z.wr_data = '0;
      repeat (2) @(negedge clk);

      // Reset state
      push(pk(0, 0, 0, 0, 0, 0)); check_vec("reset_a", obs_a);
      push(pk(0, 0, 0, 0, 0, 0)); check_vec("reset_z", obs_z);
      check_u32("reset_cycles", a_cycles, 0);
      check_u32("reset_state", 32'(a_state), 32'(ST_IDLE));
      rst = 1'b1;
      @(negedge clk);

      // Basic pass: x3=5, x27=1, x26=1; done exactly 3 cycles after the x26 drive
      en_a = 1'b1;
      @(negedge clk);
      check_u32("run_state", 32'(a_state), 32'(ST_RUN));
      wr1(0, 5'd3, 32'd5);
      push(pk(0, 0, 0, 0, 5, 0)); check_vec("shadow_testnum", obs_a);
      wr1(0, 5'd27, 32'd1);
      wr1(0, 5'd26, 32'd1);
      push(pk(0, 0, 0, 0, 5, 1)); check_vec("settle_wait_1", obs_a);
      @(negedge clk);
      push(pk(0, 0, 0, 0, 5, 1)); check_vec("settle_wait_2", obs_a);
      @(negedge clk);
      push(pk(1, 1, 0, 0, 5, 1)); check_vec("pass_verdict", obs_a);
      check_u32("pass_cycles", a_cycles, 5);
      wr1(0, 5'd27, 32'h0B);
      @(negedge clk);
      push(pk(1, 1, 0, 0, 5, 1)); check_vec("sticky_frozen", obs_a);
      en_a = 1'b0;
      @(negedge clk);
      push(pk(0, 0, 0, 0, 5, 1)); check_vec("en_low_clears", obs_a);

      // Re-arm clears shadows; then a failing result
      en_a = 1'b1;
      @(negedge clk);
      push(pk(0, 0, 0, 0, 0, 0)); check_vec("rearm_clear", obs_a);
      wr1(0, 5'd27, 32'h0B);
      wr1(0, 5'd26, 32'd1);
      repeat (2) @(negedge clk);
      push(pk(1, 0, 1, 0, 0, 32'h0B)); check_vec("fail_verdict", obs_a);
      en_a = 1'b0;
      @(negedge clk);

      // Result written inside the settle window still counts
      en_a = 1'b1;
      @(negedge clk);
      wr1(0, 5'd26, 32'd1);
      wr1(0, 5'd27, 32'd1);
      @(negedge clk);
      push(pk(1, 1, 0, 0, 0, 1)); check_vec("late_result_pass", obs_a);
      en_a = 1'b0;
      @(negedge clk);

      // Same stimulus with no settle window: verdict is immediate and fails
      en_z = 1'b1;
      @(negedge clk);
      wr1(1, 5'd26, 32'd1);
      push(pk(1, 0, 1, 0, 0, 0)); check_vec("settle0_immediate", obs_z);
      wr1(1, 5'd27, 32'd1);
      push(pk(1, 0, 1, 0, 0, 0)); check_vec("settle0_frozen", obs_z);
      en_z = 1'b0;
      @(negedge clk);
      en_z = 1'b1;
      @(negedge clk);
      drive(1, 2'b11, 5'd27, 5'd26, 32'd1, 32'd1);
      push(pk(1, 1, 0, 0, 0, 1)); check_vec("settle0_same_edge", obs_z);
      en_z = 1'b0;
      @(negedge clk);

      // Watchdog: no done write, expect timeout on cycle 51
      en_a = 1'b1;
      lat = 0; found = 1'b0;
      for (int i = 1; i <= 60 && !found; i++) begin
         @(negedge clk);
         if (a_done) begin
            found = 1'b1;
            lat = i;
         end
      end
      check_u32("timeout_latency", lat, 51);
      push(pk(1, 0, 1, 1, 0, 0)); check_vec("timeout_verdict", obs_a);
      check_u32("timeout_cycles", a_cycles, 50);
      repeat (3) @(negedge clk);
      check_u32("cycles_hold", a_cycles, 50);
      en_a = 1'b0;
      @(negedge clk);
      push(pk(0, 0, 0, 0, 0, 0)); check_vec("timeout_cleared", obs_a);

      // Done on the watchdog edge wins; settle is not subject to the watchdog
      en_a = 1'b1;
      repeat (50) @(negedge clk);
      wr1(0, 5'd26, 32'd1);
      check_u32("done_beats_timeout_state", 32'(a_state), 32'(ST_SETTLE));
      repeat (2) @(negedge clk);
      push(pk(1, 0, 1, 0, 0, 0)); check_vec("done_beats_timeout", obs_a);
      check_u32("done_beats_timeout_cycles", a_cycles, 52);
      en_a = 1'b0;
      @(negedge clk);

      // Port priority, x0 writes and zero done-writes
      en_a = 1'b1;
      @(negedge clk);
      drive(0, 2'b11, 5'd27, 5'd27, 32'd7, 32'd1);
      push(pk(0, 0, 0, 0, 0, 1)); check_vec("port_priority_result", obs_a);
      drive(0, 2'b11, 5'd3, 5'd3, 32'd9, 32'd4);
      push(pk(0, 0, 0, 0, 4, 1)); check_vec("port_priority_testnum", obs_a);
      wr1(0, 5'd0, 32'd9);
      push(pk(0, 0, 0, 0, 4, 1)); check_vec("x0_ignored", obs_a);
      wr1(0, 5'd26, 32'd0);
      repeat (3) @(negedge clk);
      push(pk(0, 0, 0, 0, 4, 1)); check_vec("done_zero_no_verdict", obs_a);
      drive(0, 2'b10, 5'd0, 5'd26, 32'd0, 32'd1);
      repeat (2) @(negedge clk);
      push(pk(1, 1, 0, 0, 4, 1)); check_vec("port1_done_pass", obs_a);
      en_a = 1'b0;
      @(negedge clk);

      // Asynchronous reset during settle aborts with no verdict
      en_a = 1'b1;
      @(negedge clk);
      wr1(0, 5'd3, 32'd6);
      wr1(0, 5'd27, 32'd1);
      wr1(0, 5'd26, 32'd1);
      check_u32("pre_reset_settle", 32'(a_state), 32'(ST_SETTLE));
      #1 rst = 1'b0;
      #1;
      push(pk(0, 0, 0, 0, 0, 0)); check_vec("async_reset", obs_a);
      check_u32("async_reset_cycles", a_cycles, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      push(pk(0, 0, 0, 0, 0, 0)); check_vec("no_verdict_after_reset", obs_a);
      en_a = 1'b0;
      @(negedge clk);

      check_u32("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_test_monitor.md
# rv_test_monitor

Synthesizable pass/fail monitor for riscv-tests style programs on `rv_soc`. It snoops one or more register-file write ports and shadows the test-number, done and result registers. Once the done register is written non-zero, it waits a settle window and then latches a sticky verdict; a cycle watchdog catches hung programs. It replaces hierarchical register peeking in benches, and the same block can drive LEDs or a status CSR on FPGA builds.

## Interface
- `WR_PORTS`, 1: number of snooped register-file write ports.
- `DATA_W`, 32: register data width.
- `REG_AW`, 5: register address width.
- `TESTNUM_REG`, 3: register holding the current test number (gp).
- `DONE_REG`, 26: register whose non-zero write signals completion.
- `RESULT_REG`, 27: register holding the result code.
- `PASS_VALUE`, 1: result value meaning pass.
- `SETTLE_CYCLES`, 2: cycles to wait after done before sampling the result.
- `TIMEOUT_CYCLES`, 100000: run-cycle watchdog limit; 0 disables it.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: arm the monitor; deasserting it aborts to IDLE.
- `wr_en` in WR_PORTS: per-port write strobe.
- `wr_addr` in WR_PORTS*REG_AW: flattened addresses, port i at bits [i*REG_AW +: REG_AW].
- `wr_data` in WR_PORTS*DATA_W: flattened write data.
- `done` out 1: verdict valid, sticky.
- `pass` out 1: result equalled PASS_VALUE.
- `fail` out 1: result mismatch or timeout.
- `timeout` out 1: watchdog expired.
- `testnum` out DATA_W: shadow of TESTNUM_REG.
- `result` out DATA_W: shadow of RESULT_REG.
- `cycles` out 32: RUN+SETTLE cycle count, saturating.

## Operation
- FSM states: IDLE, RUN, SETTLE, DONE, TIMEOUT.
- IDLE→RUN on `en`=1.
  - On entry: shadows, counters and flags clear.
- RUN: every enabled write port updates a matching shadow.
  - Writes with address 0 are ignored.
  - When several ports write the same address in one cycle, the highest port index wins.
- RUN→SETTLE when any port writes DONE_REG with non-zero data.
  - If SETTLE_CYCLES=0, go directly to DONE. The verdict uses the result shadow including same-edge writes.
- SETTLE: shadows keep updating. Down-counter is loaded with SETTLE_CYCLES and reaches DONE when it expires.
- DONE: `done`=1 and `pass`=(result==PASS_VALUE), `fail`=!pass. Shadows freeze.
- RUN→TIMEOUT when the run counter reaches TIMEOUT_CYCLES before done.
  - TIMEOUT outputs: `done`=1, `timeout`=1, `fail`=1, `pass`=0.
  - Done and timeout on the same edge: done wins.
  - SETTLE cannot time out.
- DONE/TIMEOUT are sticky while `en`=1. `en`=0 in any state→IDLE. Outputs clear next cycle; shadows hold until the next RUN entry.
- `cycles` counts cycles in RUN and SETTLE and saturates at 2^32-1.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, all outputs 0.
- Reset mid-test aborts immediately; no verdict is produced.
- All outputs are registered.
- Latency from the done-write edge to `done`=1 is SETTLE_CYCLES+1 cycles.
- Timeout: `timeout`=1 on the cycle after TIMEOUT_CYCLES RUN cycles have elapsed.
- Shadow outputs reflect a write one cycle after its edge.

## Structure
- Package `rv_test_pkg`:
  - FSM state enum;
  - default register indices (3/26/27) and PASS_VALUE.
- Sub-module `rv_wr_snoop`:
  - WR_PORTS-way address match with priority select;
  - outputs hit/data for one target register;
  - instantiated three times.

## Test plan
- WR_PORTS=1, SETTLE=2.
  - Stimulus: write x3=5, x27=1, then x26=1.
  - Response: done=1 exactly 3 cycles after the x26 edge; pass=1, fail=0, testnum=5.
- Write x27=0x0B, then x26=1.
  - Response: fail=1, pass=0, result=0x0B.
- Write x26=1, then x27=1 one cycle later (inside the settle window).
  - Response: pass=1.
  - Repeat with SETTLE=0: fail=1.
- TIMEOUT_CYCLES=50, no done write.
  - Response: timeout=fail=done=1 on cycle 51; cycles=50.
- WR_PORTS=2, same-cycle writes x27=7 (port 0) and x27=1 (port 1), then x26=1.
  - Response: result=1, pass=1.
  - Write x0=9: ignored.
- Faults:
  - `rst`=0 during SETTLE: all outputs 0 immediately.
  - `en`=0 in DONE: done=0 next cycle.
  - `en` re-armed: shadows cleared.
